instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Consumer end of the program counter: reads `pc_current`, fetches the 32-bit instruction at that address over a valid/ready memory port, and presents it to decode with a valid/ready handshake.
- Pulses `pc_advance` when decode accepts an instruction, which allows the program counter to update on that edge.
- Handles control-flow redirects (`flush`), misaligned PCs and memory timeouts.

Parameters:
- XLEN, 64, address/PC width
- ILEN, 32, instruction width
- TIMEOUT, 16, max cycles in WAIT before a fault is raised (>=1)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- pc_current  in  XLEN  address from program counter
- flush  in  1  redirect; discard any in-flight or held instruction
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  XLEN  request address (= pc_current while in REQ)
- mem_resp_valid  in  1  response valid (never earlier than the cycle after acceptance)
- mem_resp_data  in  ILEN  instruction word
- mem_resp_error  in  1  bus error with response
- inst_valid  out  1  instruction held for decode
- inst_ready  in  1  decode accepts
- inst_data  out  ILEN  instruction
- inst_pc  out  XLEN  address of inst_data
- inst_fault  out  1  misaligned, bus error or timeout
- pc_advance  out  1  combinational: inst_valid & inst_ready & ~flush

Behaviour:
- States: IDLE, REQ, WAIT, DRAIN, HOLD.
- Reset (async): state=IDLE, inst_data=32'h00000013 (NOP), inst_pc=0, inst_fault=0, timeout counter=0. All outputs low except inst_data.
- IDLE: unconditional transition to REQ on the next edge.
- REQ:
  - If pc_current[1:0]!=0: no request issued; go to HOLD with inst_fault=1, inst_data=NOP, inst_pc=pc_current.
  - Otherwise mem_req_valid=1 and mem_req_addr=pc_current.
  - On mem_req_ready: latch inst_pc=pc_current, clear counter, go to WAIT.
  - flush in REQ has no effect (the address already tracks pc_current).
- WAIT:
  - Counter increments each cycle.
  - mem_resp_valid & ~flush: inst_data=mem_resp_data, inst_fault=mem_resp_error, go to HOLD.
  - flush & ~mem_resp_valid: go to DRAIN.
  - flush & mem_resp_valid: response discarded, go to REQ.
  - Counter reaches TIMEOUT-1 with no response: go to HOLD, inst_fault=1, inst_data=NOP. A response arriving later is ignored until the next request.
- DRAIN:
  - Waits for mem_resp_valid or timeout, discards it, goes to REQ.
  - Counter continues from its WAIT value.
- HOLD:
  - inst_valid=1; data, pc and fault are stable until accepted.
  - inst_ready & ~flush: pc_advance=1 this cycle, go to REQ. The next REQ sees the updated pc_current.
  - flush: inst_valid drops next cycle, go to REQ, no pc_advance. flush has priority over inst_ready.
- Minimum latency, with memory ready immediately and a 1-cycle response:
  - REQ at cycle N, WAIT at N+1 (resp_valid), HOLD at N+2.
  - Throughput is 1 instruction per 3 cycles.
- Exactly one outstanding request at a time. No request is issued in IDLE, WAIT, DRAIN or HOLD.
- Reset mid-operation: immediate return to the reset values. Any pending memory response is not tracked.

Decomposition:
- Shared package fetch_pkg:
  - state enum (IDLE, REQ, WAIT, DRAIN, HOLD)
  - NOP_INST=32'h00000013
  - default TIMEOUT
  - XLEN/ILEN constants shared with program_counter
- One natural sub-module: fetch_timeout_counter.
  - Clear/enable inputs, expired output, width $clog2(TIMEOUT)+1.

Test Plan:
- Reset with pc_current=0, then release; mem_req_ready=1 and resp one cycle later with data 32'h00500093 -> inst_valid at the 3rd cycle after IDLE, inst_pc=0, inst_data=32'h00500093, inst_fault=0; inst_ready=1 -> pc_advance pulses for exactly 1 cycle.
- Back-pressure: mem_req_ready low for 3 cycles at pc=4 -> mem_req_valid held with addr 4 throughout; inst_ready low for 5 cycles -> inst_valid/data/pc stable, pc_advance=0.
- Flush in WAIT at pc=8, response 2 cycles later -> DRAIN discards it; new request issued at pc_current=64'h1000 and delivered with inst_pc=64'h1000.
- Flush and inst_ready in the same HOLD cycle -> pc_advance=0 and inst_valid=0 next cycle; flush coincident with resp_valid in WAIT -> response dropped, back to REQ.
- pc_current=64'h1002 -> no mem_req_valid; HOLD with inst_fault=1, inst_data=32'h00000013. mem_resp_error=1 -> inst_fault=1 with the returned data.
- No response for TIMEOUT=16 cycles -> inst_fault=1 in HOLD; reset asserted mid-WAIT -> inst_valid=0 and mem_req_valid=0 immediately, IDLE then REQ after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants; XLEN/ILEN are also used by program_counter.
package fetch_pkg;
  localparam int XLEN        = 64;
  localparam int ILEN        = 32;
  localparam int TIMEOUT_DEF = 16;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_HOLD
  } fetch_state_e;
endpackage

// File: rtl/fetch_timeout_counter.sv
// Saturating cycle counter for the outstanding memory request; expired stays high once reached.
module fetch_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] count;

  assign expired = (count >= CW'(TIMEOUT - 1));

  // Holding at the limit keeps DRAIN from wrapping if a flush lands on the expiry cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                    count <= '0;
    else if (clear)               count <= '0;
    else if (enable && !expired)  count <= count + CW'(1);
  end
endmodule

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch: PC -> memory read -> decode handshake,
// with flush redirect, misaligned-PC and timeout faults.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int XLEN    = fetch_pkg::XLEN,
  parameter int ILEN    = fetch_pkg::ILEN,
  parameter int TIMEOUT = fetch_pkg::TIMEOUT_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_current,
  input  logic            flush,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [ILEN-1:0] mem_resp_data,
  input  logic            mem_resp_error,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault,
  output logic            pc_advance
);
  fetch_state_e state;
  logic         aligned;
  logic         req_fire;
  logic         expired;

  assign aligned       = (pc_current[1:0] == 2'b00);
  assign mem_req_valid = (state == S_REQ) && aligned;
  assign mem_req_addr  = pc_current;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign inst_valid    = (state == S_HOLD);
  assign pc_advance    = inst_valid && inst_ready && !flush;

  fetch_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clock   (clock),
    .reset   (reset),
    .clear   (req_fire),
    .enable  ((state == S_WAIT) || (state == S_DRAIN)),
    .expired (expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      inst_data  <= ILEN'(NOP_INST);
      inst_pc    <= '0;
      inst_fault <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (!aligned) begin
            state      <= S_HOLD;
            inst_fault <= 1'b1;
            inst_data  <= ILEN'(NOP_INST);
            inst_pc    <= pc_current;
          end else if (mem_req_ready) begin
            state   <= S_WAIT;
            inst_pc <= pc_current;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid && !flush) begin
            state      <= S_HOLD;
            inst_data  <= mem_resp_data;
            inst_fault <= mem_resp_error;
          end else if (flush) begin
            // A response coinciding with the flush is the one we'd drain; skip DRAIN.
            state <= mem_resp_valid ? S_REQ : S_DRAIN;
          end else if (expired) begin
            state      <= S_HOLD;
            inst_fault <= 1'b1;
            inst_data  <= ILEN'(NOP_INST);
          end
        end
        S_DRAIN: if (mem_resp_valid || expired) state <= S_REQ;
        S_HOLD:  if (flush || inst_ready) state <= S_REQ;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: handshake, back-pressure, flush, faults, timeout, reset.
module tb_instruction_fetch;
  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] pc_current;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_error;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;
  logic        inst_fault;
  logic        pc_advance;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [31:0] NOP = 32'h00000013;

  instruction_fetch #(.XLEN(64), .ILEN(32), .TIMEOUT(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .pc_current     (pc_current),
    .flush          (flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_error (mem_resp_error),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault),
    .pc_advance     (pc_advance)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are changed at edge+1, outputs checked at edge+2.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic hold_chk(input string tag, input logic [31:0] d, input logic [63:0] pc,
                          input logic f);
    chk({tag, ".valid"}, 64'(inst_valid), 64'd1);
    chk({tag, ".data"},  64'(inst_data),  64'(d));
    chk({tag, ".pc"},    inst_pc,         pc);
    chk({tag, ".fault"}, 64'(inst_fault), 64'(f));
  endtask

  initial begin
    reset = 1'b1; pc_current = '0; flush = 1'b0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_error = 1'b0; inst_ready = 1'b0;
    #12;
    chk("rst.inst_valid", 64'(inst_valid), 64'd0);
    chk("rst.req_valid",  64'(mem_req_valid), 64'd0);
    chk("rst.inst_data",  64'(inst_data), 64'(NOP));
    chk("rst.inst_pc",    inst_pc, 64'd0);
    chk("rst.inst_fault", 64'(inst_fault), 64'd0);
    chk("rst.pc_advance", 64'(pc_advance), 64'd0);
    @(negedge clock); reset = 1'b0;

    // Basic fetch at pc=0: IDLE -> REQ -> WAIT -> HOLD
    cyc(); mem_req_ready = 1'b1; #1;
    chk("b.req_valid", 64'(mem_req_valid), 64'd1);
    chk("b.req_addr",  mem_req_addr, 64'd0);
    cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h00500093; #1;
    chk("b.wait_noreq", 64'(mem_req_valid), 64'd0);
    chk("b.wait_novld", 64'(inst_valid), 64'd0);
    cyc(); mem_resp_valid = 1'b0; #1;
    hold_chk("b.hold", 32'h00500093, 64'd0, 1'b0);
    chk("b.adv_noready", 64'(pc_advance), 64'd0);
    inst_ready = 1'b1; #1;
    chk("b.adv", 64'(pc_advance), 64'd1);
    cyc(); inst_ready = 1'b0; pc_current = 64'd4; #1;
    chk("b.adv_pulse", 64'(pc_advance), 64'd0);
    chk("b.vld_drop",  64'(inst_valid), 64'd0);

    // Request back-pressure at pc=4
    for (int i = 0; i < 3; i++) begin
      chk("bp.req_valid", 64'(mem_req_valid), 64'd1);
      chk("bp.req_addr",  mem_req_addr, 64'd4);
      cyc();
    end
    mem_req_ready = 1'b1; #1;
    cyc(); mem_req_ready = 1'b0; #1;
    cyc(); mem_resp_valid = 1'b1; mem_resp_data = 32'h00a00113; #1;
    cyc(); mem_resp_valid = 1'b0; #1;
    // Decode back-pressure
    for (int i = 0; i < 5; i++) begin
      hold_chk("bp.hold", 32'h00a00113, 64'd4, 1'b0);
      chk("bp.no_adv", 64'(pc_advance), 64'd0);
      cyc();
    end
    inst_ready = 1'b1; #1;
    chk("bp.adv", 64'(pc_advance), 64'd1);
    cyc(); inst_ready = 1'b0; pc_current = 64'd8; mem_req_ready = 1'b1; #1;

    // Flush in WAIT, late response drained, redirect to 0x1000
    chk("fw.req_addr", mem_req_addr, 64'd8);
    cyc(); mem_req_ready = 1'b0; flush = 1'b1; #1;
    cyc(); flush = 1'b0; pc_current = 64'h1000; #1;
    chk("fw.drain_noreq", 64'(mem_req_valid), 64'd0);
    cyc(); mem_resp_valid = 1'b1; mem_resp_data = 32'hdeadbeef; #1;
    chk("fw.drain_novld", 64'(inst_valid), 64'd0);
    cyc(); mem_resp_valid = 1'b0; mem_req_ready = 1'b1; #1;
    chk("fw.req_valid", 64'(mem_req_valid), 64'd1);
    chk("fw.req_addr2", mem_req_addr, 64'h1000);
    cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h00100073; #1;
    cyc(); mem_resp_valid = 1'b0; #1;
    hold_chk("fw.hold", 32'h00100073, 64'h1000, 1'b0);

    // Flush wins over inst_ready in HOLD
    flush = 1'b1; inst_ready = 1'b1; #1;
    chk("fh.no_adv", 64'(pc_advance), 64'd0);
    cyc(); flush = 1'b0; inst_ready = 1'b0; #1;
    chk("fh.vld_drop", 64'(inst_valid), 64'd0);
    chk("fh.req_valid", 64'(mem_req_valid), 64'd1);

    // Flush coincident with response in WAIT: straight back to REQ
    mem_req_ready = 1'b1;
    cyc(); mem_req_ready = 1'b0; flush = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'h11111111; #1;
    cyc(); flush = 1'b0; mem_resp_valid = 1'b0; #1;
    chk("fr.req_valid", 64'(mem_req_valid), 64'd1);
    chk("fr.novld", 64'(inst_valid), 64'd0);

    // Misaligned PC
    pc_current = 64'h1002; #1;
    chk("mis.noreq", 64'(mem_req_valid), 64'd0);
    cyc(); #1;
    hold_chk("mis.hold", NOP, 64'h1002, 1'b1);
    inst_ready = 1'b1;
    cyc(); inst_ready = 1'b0; pc_current = 64'h2000; mem_req_ready = 1'b1; #1;

    // Bus error response
    cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_error = 1'b1;
    mem_resp_data = 32'hcafef00d; #1;
    cyc(); mem_resp_valid = 1'b0; mem_resp_error = 1'b0; #1;
    hold_chk("berr.hold", 32'hcafef00d, 64'h2000, 1'b1);
    inst_ready = 1'b1;
    cyc(); inst_ready = 1'b0; pc_current = 64'h3000; mem_req_ready = 1'b1; #1;

    // Timeout: 16 WAIT cycles without response
    cyc(); mem_req_ready = 1'b0; #1;
    for (int i = 0; i < 15; i++) begin
      chk("tmo.waiting", 64'(inst_valid), 64'd0);
      cyc();
    end
    chk("tmo.last_wait", 64'(inst_valid), 64'd0);
    cyc(); #1;
    hold_chk("tmo.hold", NOP, 64'h3000, 1'b1);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h12345678;
    cyc(); mem_resp_valid = 1'b0; #1;
    hold_chk("tmo.late_ignored", NOP, 64'h3000, 1'b1);
    inst_ready = 1'b1;
    cyc(); inst_ready = 1'b0; pc_current = 64'h4000; mem_req_ready = 1'b1; #1;

    // Reset in the middle of WAIT
    cyc(); mem_req_ready = 1'b0; #1;
    cyc(); reset = 1'b1; #1;
    chk("mr.inst_valid", 64'(inst_valid), 64'd0);
    chk("mr.req_valid",  64'(mem_req_valid), 64'd0);
    chk("mr.inst_pc",    inst_pc, 64'd0);
    chk("mr.inst_data",  64'(inst_data), 64'(NOP));
    reset = 1'b0; #1;
    chk("mr.idle_noreq", 64'(mem_req_valid), 64'd0);
    cyc(); #1;
    chk("mr.req_valid2", 64'(mem_req_valid), 64'd1);
    chk("mr.req_addr",   mem_req_addr, 64'h4000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
